motoro3_pwm_multi: RTL and testbench
====================================

// Module: motoro3_pwm_multi
// PURPOSE
//  Multi-channel carrier PWM generator for the 3-phase motor drive; successor of the single-channel step PWM.
//  Each channel gets a per-period on-time from its duty word. Pulses shorter than a minimum are suppressed
//  and their on-time is carried into the next period. A commutation-step boundary restarts the carrier
//  and discards any carry. Sits between the step sequencer (stepLast1, duty) and the MOS driver pins.
// PARAMETERS
//  CH     3   number of PWM channels
//  CNT_W  12  carrier/duty counter width (max period 2^CNT_W-1 clk)
//  DEAD_W 6   dead-time counter width (used only with MOTORO3_PWM_DEADTIME_EN)
// PORTS
//  clk          in   1          system clock, 10 MHz; all state on rising edge
//  rst          in   1          reset, asynchronous, active-high
//  enable       in   1          run request
//  periodLen    in   CNT_W      carrier period in clk cycles; 0 = stop
//  dutyWant     in   CH*CNT_W   per-channel on-time request per period; channel i = [i*CNT_W +: CNT_W]
//  minPulse     in   CNT_W      shortest on-time allowed on a pin
//  stepLast1    in   1          last cycle of a commutation step
//  deadLen      in   DEAD_W     dead time in clk cycles (ignored without macro)
//  pwm          out  CH         high-side drive, registered
//  pwmN         out  CH         low-side drive, registered
//  periodStart  out  1          1 in first cycle (pCnt==0) of every RUN period
// BEHAVIOUR
//  - Reset: FSM=IDLE, pCnt=0, onTime/carry/plenSh=0, pwm=0, pwmN=0, periodStart=0; takes effect immediately (async).
//  - FSM IDLE->RUN when enable & periodLen!=0. RUN->IDLE when !enable | periodLen==0, sampled any cycle.
//    The abort is immediate, mid-period included. Next cycle all outputs are 0 and carries are cleared.
//  - Period-end cycle (PE) = (IDLE & go) | (RUN & (pCnt==plenSh-1 | stepLast1)).
//  - At PE, for every channel: plenSh<=periodLen; sum=carry+duty (CNT_W+1 bits, no overflow).
//    If stepLast1, carry is taken as 0. If sum<minPulse: onTime<=0, carry<=sum (carry<=0 if stepLast1).
//    Otherwise: onTime<=min(sum,periodLen), carry<=0.
//  - RUN: pCnt<=0 after PE, else pCnt+1. The first RUN cycle after PE has pCnt==0 and periodStart=1.
//  - pwm[i]=1 exactly in RUN cycles with pCnt<onTime[i]. onTime=periodLen gives 100%; duty>=periodLen clips to 100%.
//  - periodLen/dutyWant/minPulse changes take effect only at the next PE; the current period always completes.
//  - stepLast1 during IDLE is ignored. stepLast1 coinciding with the natural period end is a single PE.
//  - Without macro: pwmN=0 constantly.
// CONFIGURATION
//  MOTORO3_PWM_DEADTIME_EN defined: raw[i]=(pCnt<onTime[i]) in RUN.
//    pwm[i] = raw[i] with each rising edge delayed deadLen cycles.
//    pwmN[i] = (RUN & ~raw[i]) with each rising edge delayed deadLen cycles.
//    Falling edges are not delayed. Pulses no longer than deadLen vanish. pwm[i]&pwmN[i] is never 1.
//    deadLen=0 gives pwmN as the exact complement in RUN. Both outputs are 0 in IDLE.
//  Macro not defined: no dead-time counters; deadLen is unused; pwmN tied 0.
// STRUCTURE
//  Package motoro3_pwm_pkg holds: CNT_W/DEAD_W defaults, FSM enum {ST_IDLE, ST_RUN}, and a min() function.
//  Sub-module motoro3_pwm_chan (per channel; generate loop over CH) holds carry, onTime, compare and dead-time.
//  Top level holds the FSM, pCnt, plenSh, PE decode and periodStart.
// TESTING
//  1 periodLen=10, duty={3,5,10}, minPulse=0 -> pwm0 3/10, pwm1 5/10, pwm2 always 1; periodStart every 10 clk.
//  2 minPulse=4, duty0=3 -> pwm0 on-times per period 0,6,0,6...; carry never exceeds 3.
//  3 As test 2, stepLast1 at the end of period 1 -> period 2 on-time 0 (carry dropped).
//    stepLast1 mid-period -> periodStart on the next cycle.
//  4 periodLen 10->6 mid-period -> current period lasts 10, next 6; duty0=8 then gives 100% (6/6).
//  5 enable=0 at pCnt=2 -> next cycle pwm=0, FSM IDLE. Re-enable -> first period at full duty, carry 0.
//    Async rst mid-RUN -> outputs 0 the same cycle.
//  6 Macro on, periodLen=10, duty=5, deadLen=2 -> pwm high pCnt 2..4, pwmN high pCnt 7..9;
//    duty=2 -> pwm never high; assert pwm&pwmN==0 always.

Source files
------------

// File: rtl/motoro3_pwm_multi_pkg.sv
// Shared types and defaults for the multi-channel carrier PWM.
`timescale 1ns/1ps
package motoro3_pwm_pkg;

  localparam int unsigned CH_DEF     = 3;
  localparam int unsigned CNT_W_DEF  = 12;
  localparam int unsigned DEAD_W_DEF = 6;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_RUN
  } state_e;

  function automatic int unsigned min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/motoro3_pwm_multi_if.sv
// Sequencer-facing and driver-facing signals of the multi-channel PWM.
`timescale 1ns/1ps
interface motoro3_pwm_multi_if #(
  parameter int unsigned CH     = 3,
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned DEAD_W = 6
);
  logic                  enable;
  logic [CNT_W-1:0]      periodLen;
  logic [CH*CNT_W-1:0]   dutyWant;
  logic [CNT_W-1:0]      minPulse;
  logic                  stepLast1;
  logic [DEAD_W-1:0]     deadLen;
  logic [CH-1:0]         pwm;
  logic [CH-1:0]         pwmN;
  logic                  periodStart;

  modport master (
    output enable, periodLen, dutyWant, minPulse, stepLast1, deadLen,
    input  pwm, pwmN, periodStart
  );

  modport slave (
    input  enable, periodLen, dutyWant, minPulse, stepLast1, deadLen,
    output pwm, pwmN, periodStart
  );
endinterface

// File: rtl/motoro3_pwm_chan.sv
// One PWM channel: carry of suppressed pulses, on-time compare, optional dead time.
// Dead-time insertion is built only with MOTORO3_PWM_DEADTIME_EN defined.
`timescale 1ns/1ps
module motoro3_pwm_chan import motoro3_pwm_pkg::*; #(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned DEAD_W = DEAD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pe_i,
  input  logic              step_i,
  input  logic              run_d_i,
  input  logic [CNT_W-1:0]  pcnt_d_i,
  input  logic [CNT_W-1:0]  period_len_i,
  input  logic [CNT_W-1:0]  duty_i,
  input  logic [CNT_W-1:0]  min_pulse_i,
  input  logic [DEAD_W-1:0] dead_len_i,
  output logic              pwm_o,
  output logic              pwmn_o
);

  logic [CNT_W-1:0] on_q, on_d, carry_q, carry_d, carry_in;
  logic [CNT_W:0]   sum;
  logic             raw_d, pwm_d, pwm_q, pwmn_d, pwmn_q;

  always_comb begin
    carry_in = step_i ? '0 : carry_q;
    sum      = {1'b0, carry_in} + {1'b0, duty_i};
    on_d     = on_q;
    carry_d  = carry_q;
    if (!run_d_i) begin
      on_d    = '0;
      carry_d = '0;
    end else if (pe_i) begin
      if (sum < {1'b0, min_pulse_i}) begin
        on_d    = '0;
        carry_d = step_i ? '0 : sum[CNT_W-1:0];
      end else begin
        on_d    = CNT_W'(min(32'(sum), 32'(period_len_i)));
        carry_d = '0;
      end
    end
    // Outputs are registered, so decode against next-cycle counter and on-time.
    raw_d = run_d_i & (pcnt_d_i < on_d);
  end

`ifdef MOTORO3_PWM_DEADTIME_EN
  logic              raw_q, rawn_q, rawn_d;
  logic [DEAD_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;

  // hcnt/lcnt count how many earlier consecutive cycles the level has already held.
  always_comb begin
    rawn_d = run_d_i & ~raw_d;
    hcnt_d = raw_q  ? ((hcnt_q == '1) ? hcnt_q : hcnt_q + 1'b1) : '0;
    lcnt_d = rawn_q ? ((lcnt_q == '1) ? lcnt_q : lcnt_q + 1'b1) : '0;
    pwm_d  = raw_d  & (hcnt_d >= dead_len_i);
    pwmn_d = rawn_d & (lcnt_d >= dead_len_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q  <= 1'b0;
      rawn_q <= 1'b0;
      hcnt_q <= '0;
      lcnt_q <= '0;
    end else begin
      raw_q  <= raw_d;
      rawn_q <= rawn_d;
      hcnt_q <= hcnt_d;
      lcnt_q <= lcnt_d;
    end
  end
`else
  logic unused_dead;

  always_comb begin
    unused_dead = ^dead_len_i;
    pwm_d       = raw_d;
    pwmn_d      = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      on_q    <= '0;
      carry_q <= '0;
      pwm_q   <= 1'b0;
      pwmn_q  <= 1'b0;
    end else begin
      on_q    <= on_d;
      carry_q <= carry_d;
      pwm_q   <= pwm_d;
      pwmn_q  <= pwmn_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign pwmn_o = pwmn_q;

endmodule

// File: rtl/motoro3_pwm_multi.sv
// Multi-channel carrier PWM top: run FSM, carrier counter, period-end decode.
// Optional dead time (inside each channel) is enabled by MOTORO3_PWM_DEADTIME_EN.
`timescale 1ns/1ps
module motoro3_pwm_multi import motoro3_pwm_pkg::*; #(
  parameter int unsigned CH     = CH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned DEAD_W = DEAD_W_DEF
) (
  input logic                clk,
  input logic                rst,
  motoro3_pwm_multi_if.slave bus
);

  state_e           st_q, st_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, plen_q, plen_d;
  logic             period_start_q, period_start_d;
  logic             go, step, pe;
  logic [CH-1:0]    pwm, pwmn;

  always_comb begin
    go   = bus.enable & (bus.periodLen != '0);
    step = (st_q == ST_RUN) & bus.stepLast1;
    // An abort (go low) overrides any period end in the same cycle.
    pe   = go & ((st_q == ST_IDLE) | (pcnt_q == plen_q - 1'b1) | bus.stepLast1);
    st_d = st_q;
    unique case (st_q)
      ST_IDLE: if (go)  st_d = ST_RUN;
      ST_RUN:  if (!go) st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
    pcnt_d         = (pe | ~go) ? '0 : pcnt_q + 1'b1;
    plen_d         = pe ? bus.periodLen : (go ? plen_q : '0);
    period_start_d = pe;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q           <= ST_IDLE;
      pcnt_q         <= '0;
      plen_q         <= '0;
      period_start_q <= 1'b0;
    end else begin
      st_q           <= st_d;
      pcnt_q         <= pcnt_d;
      plen_q         <= plen_d;
      period_start_q <= period_start_d;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_chan
    motoro3_pwm_chan #(
      .CNT_W  (CNT_W),
      .DEAD_W (DEAD_W)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .pe_i         (pe),
      .step_i       (step),
      .run_d_i      (go),
      .pcnt_d_i     (pcnt_d),
      .period_len_i (bus.periodLen),
      .duty_i       (bus.dutyWant[i*CNT_W +: CNT_W]),
      .min_pulse_i  (bus.minPulse),
      .dead_len_i   (bus.deadLen),
      .pwm_o        (pwm[i]),
      .pwmn_o       (pwmn[i])
    );
  end

  always_comb begin
    bus.pwm         = pwm;
    bus.pwmN        = pwmn;
    bus.periodStart = period_start_q;
  end

endmodule

// File: tb/tb_motoro3_pwm_multi.sv
// Self-checking bench for motoro3_pwm_multi: vector table, corner sequences, random vs model.
`timescale 1ns/1ps
module tb_motoro3_pwm_multi;
  localparam int CH = 3;
  localparam int CW = 12;
  localparam int DW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  motoro3_pwm_multi_if #(.CH(CH), .CNT_W(CW), .DEAD_W(DW)) bus ();

  motoro3_pwm_multi #(.CH(CH), .CNT_W(CW), .DEAD_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #50 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus as plain integers.
  bit in_en, in_step;
  int in_len, in_min, in_dead;
  int in_duty[CH];

  // Reference model: period-level state of the carrier and per-channel bookkeeping.
  bit m_run;
  int m_pos, m_len;
  int m_on[CH], m_carry[CH], m_hi[CH], m_lo[CH];
  logic [CH-1:0] e_pwm, e_pwmn;
  logic e_ps;

  int cnt_hi[CH];
  int cnt_ps;

  typedef struct {
    int len; int d0; int d1; int d2; int mn; int n;
    int e0; int e1; int e2; int eps;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.enable    = in_en;
    bus.periodLen = CW'(in_len);
    for (int i = 0; i < CH; i++) bus.dutyWant[i*CW +: CW] = CW'(in_duty[i]);
    bus.minPulse  = CW'(in_min);
    bus.stepLast1 = in_step;
    bus.deadLen   = DW'(in_dead);
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_len = 0;
    for (int i = 0; i < CH; i++) begin
      m_on[i] = 0; m_carry[i] = 0; m_hi[i] = 0; m_lo[i] = 0;
    end
    e_pwm = '0; e_pwmn = '0; e_ps = 1'b0;
  endtask

  task automatic model_step();
    bit go, brk, raw, rawn;
    int c, s;
    go = in_en && (in_len != 0);
    if (!go) begin
      m_run = 0; m_pos = 0;
      for (int i = 0; i < CH; i++) begin m_on[i] = 0; m_carry[i] = 0; end
    end else if (!m_run || (m_pos == m_len - 1) || in_step) begin
      brk = m_run && in_step;
      for (int i = 0; i < CH; i++) begin
        c = brk ? 0 : m_carry[i];
        s = c + in_duty[i];
        if (s < in_min) begin
          m_on[i] = 0; m_carry[i] = brk ? 0 : s;
        end else begin
          m_on[i] = (s < in_len) ? s : in_len; m_carry[i] = 0;
        end
      end
      m_len = in_len; m_pos = 0; m_run = 1;
    end else begin
      m_pos++;
    end
    e_ps = m_run && (m_pos == 0);
    for (int i = 0; i < CH; i++) begin
      raw  = m_run && (m_pos < m_on[i]);
      rawn = m_run && !raw;
      m_hi[i] = raw  ? m_hi[i] + 1 : 0;
      m_lo[i] = rawn ? m_lo[i] + 1 : 0;
`ifdef MOTORO3_PWM_DEADTIME_EN
      e_pwm[i]  = raw  && (m_hi[i] > in_dead);
      e_pwmn[i] = rawn && (m_lo[i] > in_dead);
`else
      e_pwm[i]  = raw;
      e_pwmn[i] = 1'b0;
`endif
    end
  endtask

  task automatic tick();
    drive();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("cycle", int'({bus.pwm, bus.pwmN, bus.periodStart}), int'({e_pwm, e_pwmn, e_ps}));
    check("overlap", int'(|(bus.pwm & bus.pwmN)), 0);
    for (int i = 0; i < CH; i++) cnt_hi[i] += int'(bus.pwm[i]);
    cnt_ps += int'(bus.periodStart);
  endtask

  task automatic clr_counts();
    for (int i = 0; i < CH; i++) cnt_hi[i] = 0;
    cnt_ps = 0;
  endtask

  task automatic set_cfg(input int len, input int d0, input int d1, input int d2, input int mn);
    in_en = 1; in_len = len; in_min = mn; in_step = 0;
    in_duty[0] = d0; in_duty[1] = d1; in_duty[2] = d2;
  endtask

  task automatic reset_dut();
    in_en = 0; in_len = 0; in_min = 0; in_step = 0; in_dead = 0;
    for (int i = 0; i < CH; i++) in_duty[i] = 0;
    drive();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_to_pos(input int p);
    for (int k = 0; k < 64 && m_pos != p; k++) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, h0, h1;
    tbl[0] = '{10, 3, 5, 10, 0, 30, 9, 15, 30, 3};
    tbl[1] = '{10, 3, 12, 0, 4, 40, 12, 40, 0, 4};
    tbl[2] = '{6, 1, 2, 6, 0, 12, 2, 4, 12, 2};
    tbl[3] = '{1, 0, 1, 5, 0, 5, 0, 5, 5, 5};
    tbl[4] = '{10, 4, 3, 0, 4, 20, 8, 6, 0, 2};

    reset_dut();
    check("reset_out", int'({bus.pwm, bus.pwmN, bus.periodStart}), 0);

    // Vector table: on-cycle and period-start counts over whole periods from IDLE.
    foreach (tbl[v]) begin
      reset_dut();
      set_cfg(tbl[v].len, tbl[v].d0, tbl[v].d1, tbl[v].d2, tbl[v].mn);
      clr_counts();
      repeat (tbl[v].n) tick();
      check("tbl_on0", cnt_hi[0], tbl[v].e0);
      check("tbl_on1", cnt_hi[1], tbl[v].e1);
      check("tbl_on2", cnt_hi[2], tbl[v].e2);
      check("tbl_ps", cnt_ps, tbl[v].eps);
    end

    // Step at natural period end drops the carry; mid-period step restarts the carrier.
    reset_dut();
    set_cfg(10, 3, 0, 0, 4);
    tick();
    run_to_pos(9);
    in_step = 1; tick(); in_step = 0;
    check("step_end_ps", int'(bus.periodStart), 1);
    h0 = int'(bus.pwm[0]);
    repeat (9) begin tick(); h0 += int'(bus.pwm[0]); end
    check("step_drop_on", h0, 0);
    tick();
    check("step_single_pe", int'(bus.periodStart), 1);
    run_to_pos(4);
    in_step = 1; tick(); in_step = 0;
    check("step_mid_ps", int'(bus.periodStart), 1);
    h0 = int'(bus.pwm[0]);
    repeat (9) begin tick(); h0 += int'(bus.pwm[0]); end
    check("step_mid_drop", h0, 0);

    // Period length change takes effect at the next period end; duty above it clips.
    reset_dut();
    set_cfg(10, 8, 0, 0, 0);
    tick();
    run_to_pos(3);
    in_len = 6;
    n = 0;
    for (int k = 0; k < 30; k++) begin tick(); n++; if (bus.periodStart) break; end
    check("len_old_period", n, 7);
    h0 = int'(bus.pwm[0]);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      tick(); n++;
      if (bus.periodStart) break;
      h0 += int'(bus.pwm[0]);
    end
    check("len_new_period", n, 6);
    check("len_clip_full", h0, 6);

    // Abort mid-period clears carries; then async reset mid-run.
    reset_dut();
    set_cfg(10, 3, 5, 10, 4);
    tick();
    run_to_pos(2);
    in_en = 0; tick();
    check("abort_pwm", int'(bus.pwm), 0);
    check("abort_ps", int'(bus.periodStart), 0);
    tick();
    in_en = 1; tick();
    h0 = int'(bus.pwm[0]); h1 = int'(bus.pwm[1]);
    repeat (9) begin tick(); h0 += int'(bus.pwm[0]); h1 += int'(bus.pwm[1]); end
    check("reen_on0", h0, 0);
    check("reen_on1", h1, 5);
    check("pre_rst_pwm2", int'(bus.pwm[2]), 1);
    #10 rst = 1'b1;
    #1 check("async_rst", int'({bus.pwm, bus.pwmN, bus.periodStart}), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

`ifdef MOTORO3_PWM_DEADTIME_EN
    begin
      logic [9:0] pm, pn;
      reset_dut();
      set_cfg(10, 5, 0, 0, 0);
      in_dead = 2;
      tick();
      for (int k = 0; k < 10; k++) begin
        pm[k] = bus.pwm[0]; pn[k] = bus.pwmN[0]; tick();
      end
      check("dead_pwm_mask", int'(pm), 'h01C);
      check("dead_pwmn_mask", int'(pn), 'h380);
      in_duty[0] = 2;
      repeat (10) tick();
      clr_counts();
      repeat (10) tick();
      check("dead_short_gone", cnt_hi[0], 0);
    end
`else
    check("pwmn_tied", int'(bus.pwmN), 0);
`endif

    // Random stimulus against the model.
    reset_dut();
    set_cfg(8, 3, 5, 9, 2);
    for (int k = 0; k < 3000; k++) begin
      if (in_en) begin
        if ($urandom_range(0, 59) == 0) in_en = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        in_en = 1;
      end
      if ($urandom_range(0, 24) == 0) in_len = int'($urandom_range(0, 12));
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 9) == 0) in_duty[i] = int'($urandom_range(0, 14));
      if ($urandom_range(0, 29) == 0) in_min = int'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) in_dead = int'($urandom_range(0, 3));
      in_step = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
